// File: rtl/accent_pkg.sv
// Shared types and register-map constants for the accent flash controller.
package accent_pkg;

    // Blink sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    // Avalon word addresses
    localparam logic [1:0] ADDR_BASE   = 2'd0;
    localparam logic [1:0] ADDR_FLASH  = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    // CTRL / STATUS field positions
    localparam int CTRL_PF_LSB   = 0;
    localparam int CTRL_REP_LSB  = 8;
    localparam int CTRL_EN_BIT   = 31;
    localparam int STAT_BUSY_BIT = 31;

endpackage

// File: rtl/accent_regs.sv
// Avalon-MM register file and read mux for the accent flash controller.
// Exposes the next-cycle BASE/FLASH values so the colour output register
// can follow a write without an extra cycle of delay.
module accent_regs
    import accent_pkg::*;
#(
    parameter int COLOR_W  = 24,
    parameter int FRAME_W  = 8,
    parameter int REPEAT_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    input  logic                busy,
    input  logic [REPEAT_W-1:0] rep_cnt,
    input  logic [FRAME_W-1:0]  frm_cnt,
    output logic [COLOR_W-1:0]  base_nx,
    output logic [COLOR_W-1:0]  flash_nx,
    output logic [FRAME_W-1:0]  phase_frames,
    output logic [REPEAT_W-1:0] repeats,
    output logic                en,
    output logic                abort
);

    logic [COLOR_W-1:0]  base_q;
    logic [COLOR_W-1:0]  flash_q;
    logic [FRAME_W-1:0]  phase_q;
    logic [REPEAT_W-1:0] rep_q;
    logic                en_q;
    logic                wr;
    logic                unused_wdata;

    assign wr           = chipselect && !write_n;
    assign unused_wdata = ^writedata;

    // A STATUS write, or a CTRL write that clears EN, cancels any sequence
    assign abort = wr && ((address == ADDR_STATUS) ||
                          ((address == ADDR_CTRL) && !writedata[CTRL_EN_BIT]));

    assign base_nx  = (wr && address == ADDR_BASE)  ? writedata[COLOR_W-1:0] : base_q;
    assign flash_nx = (wr && address == ADDR_FLASH) ? writedata[COLOR_W-1:0] : flash_q;

    assign phase_frames = phase_q;
    assign repeats      = rep_q;
    assign en           = en_q;

    // Register writes with synchronous reset to power-on values
    always_ff @(posedge clk) begin
        if (reset) begin
            base_q  <= '0;
            flash_q <= '1;
            phase_q <= '0;
            rep_q   <= '0;
            en_q    <= 1'b0;
        end else begin
            base_q  <= base_nx;
            flash_q <= flash_nx;
            if (wr && address == ADDR_CTRL) begin
                phase_q <= writedata[CTRL_PF_LSB +: FRAME_W];
                rep_q   <= writedata[CTRL_REP_LSB +: REPEAT_W];
                en_q    <= writedata[CTRL_EN_BIT];
            end
        end
    end

    // Zero-wait-state read mux; unused bits read as zero
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_BASE:   readdata[COLOR_W-1:0] = base_q;
            ADDR_FLASH:  readdata[COLOR_W-1:0] = flash_q;
            ADDR_CTRL: begin
                readdata[CTRL_PF_LSB +: FRAME_W]   = phase_q;
                readdata[CTRL_REP_LSB +: REPEAT_W] = rep_q;
                readdata[CTRL_EN_BIT]              = en_q;
            end
            ADDR_STATUS: begin
                readdata[CTRL_PF_LSB +: FRAME_W]   = frm_cnt;
                readdata[CTRL_REP_LSB +: REPEAT_W] = rep_cnt;
                readdata[STAT_BUSY_BIT]            = busy;
            end
            default: readdata = '0;
        endcase
    end

endmodule

// File: rtl/accent_flash_ctrl.sv
// Per-player accent colour driver: shows BASE normally and blinks
// FLASH/BASE for a programmable number of frame-timed repeats after a hit.
module accent_flash_ctrl
    import accent_pkg::*;
#(
    parameter int COLOR_W  = 24,
    parameter int FRAME_W  = 8,
    parameter int REPEAT_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [31:0]        writedata,
    output logic [31:0]        readdata,
    input  logic               frame_tick,
    input  logic               hit,
    output logic [COLOR_W-1:0] accent_out,
    output logic               busy
);

    state_t              state, state_nx;
    logic [REPEAT_W-1:0] rep_cnt, rep_nx;
    logic [FRAME_W-1:0]  frm_cnt, frm_nx;
    logic [COLOR_W-1:0]  accent_nx;
    logic [COLOR_W-1:0]  base_nx, flash_nx;
    logic [FRAME_W-1:0]  phase_frames, phase_lim;
    logic [REPEAT_W-1:0] repeats;
    logic [FRAME_W:0]    frm_p1;
    logic                en, abort, start, phase_end;

    accent_regs #(
        .COLOR_W  (COLOR_W),
        .FRAME_W  (FRAME_W),
        .REPEAT_W (REPEAT_W)
    ) u_regs (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .chipselect   (chipselect),
        .write_n      (write_n),
        .writedata    (writedata),
        .readdata     (readdata),
        .busy         (busy),
        .rep_cnt      (rep_cnt),
        .frm_cnt      (frm_cnt),
        .base_nx      (base_nx),
        .flash_nx     (flash_nx),
        .phase_frames (phase_frames),
        .repeats      (repeats),
        .en           (en),
        .abort        (abort)
    );

    // PHASE_FRAMES of zero behaves as one; >= keeps the counter from running
    // past a limit that was lowered mid-phase
    assign phase_lim = (phase_frames == '0) ? FRAME_W'(1) : phase_frames;
    assign frm_p1    = {1'b0, frm_cnt} + (FRAME_W+1)'(1);
    assign phase_end = frame_tick && (frm_p1 >= {1'b0, phase_lim});
    assign start     = hit && en && (repeats != '0);

    // State, counters, busy and colour output register
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rep_cnt    <= '0;
            frm_cnt    <= '0;
            busy       <= 1'b0;
            accent_out <= '0;
        end else begin
            state      <= state_nx;
            rep_cnt    <= rep_nx;
            frm_cnt    <= frm_nx;
            busy       <= (state_nx != IDLE);
            accent_out <= accent_nx;
        end
    end

    // Next state: abort beats hit, hit beats a coinciding frame tick
    always_comb begin
        state_nx = state;
        rep_nx   = rep_cnt;
        frm_nx   = frm_cnt;
        if (abort) begin
            state_nx = IDLE;
            rep_nx   = '0;
            frm_nx   = '0;
        end else if (start) begin
            state_nx = ON;
            rep_nx   = repeats;
            frm_nx   = '0;
        end else begin
            case (state)
                ON: begin
                    if (phase_end) begin
                        state_nx = OFF;
                        frm_nx   = '0;
                    end else if (frame_tick) begin
                        frm_nx = frm_p1[FRAME_W-1:0];
                    end
                end
                OFF: begin
                    if (phase_end) begin
                        frm_nx   = '0;
                        rep_nx   = rep_cnt - REPEAT_W'(1);
                        state_nx = (rep_cnt == REPEAT_W'(1)) ? IDLE : ON;
                    end else if (frame_tick) begin
                        frm_nx = frm_p1[FRAME_W-1:0];
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    // Output colour for the coming state, tracking same-cycle BASE/FLASH writes
    always_comb begin
        accent_nx = (state_nx == ON) ? flash_nx : base_nx;
    end

endmodule

// File: tb/tb_accent_flash_ctrl.sv
// Directed testbench for accent_flash_ctrl with hand-computed expectations.
module tb_accent_flash_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        frame_tick;
    logic        hit;
    logic [23:0] accent_out;
    logic        busy;

    int n_chk = 0;
    int n_bad = 0;

    accent_flash_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .frame_tick (frame_tick),
        .hit        (hit),
        .accent_out (accent_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs settle and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic pulse_hit();
        hit = 1'b1;
        step();
        hit = 1'b0;
    endtask

    task automatic ftick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    // Run 12 ticks of a REPEATS=2, PHASE_FRAMES=3 blink and check each phase colour
    task automatic run_blink12(input string tag);
        logic [31:0] exp;
        for (int i = 0; i < 12; i++) begin
            exp = ((i / 3) % 2 == 0) ? 32'hFF0000 : 32'h102030;
            check($sformatf("%s_t%0d", tag, i), {8'h0, accent_out}, exp);
            ftick();
        end
        check({tag, "_end_busy"}, {31'h0, busy}, 32'h0);
        check({tag, "_end_col"}, {8'h0, accent_out}, 32'h102030);
    endtask

    initial begin
        logic [31:0] rd;
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        frame_tick = 1'b0;
        hit        = 1'b0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        bus_rd(2'd0, rd); check("rst_base", rd, 32'h0);
        bus_rd(2'd1, rd); check("rst_flash", rd, 32'h00FFFFFF);
        bus_rd(2'd2, rd); check("rst_ctrl", rd, 32'h0);
        bus_rd(2'd3, rd); check("rst_status", rd, 32'h0);
        check("rst_accent", {8'h0, accent_out}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);

        // Basic blink sequence
        bus_wr(2'd0, 32'h00102030);
        check("idle_base", {8'h0, accent_out}, 32'h102030);
        bus_wr(2'd1, 32'h00FF0000);
        bus_wr(2'd2, 32'h80000203);
        bus_rd(2'd2, rd); check("ctrl_rb", rd, 32'h80000203);
        pulse_hit();
        check("hit_busy", {31'h0, busy}, 32'h1);
        bus_rd(2'd3, rd); check("hit_status", rd, 32'h80000200);
        run_blink12("seq1");

        // Restart after 4 ticks
        pulse_hit();
        for (int i = 0; i < 4; i++) ftick();
        bus_rd(2'd3, rd); check("mid_status", rd, 32'h80000201);
        check("mid_col", {8'h0, accent_out}, 32'h102030);
        pulse_hit();
        bus_rd(2'd3, rd); check("rst_seq_status", rd, 32'h80000200);
        run_blink12("seq2");

        // PHASE_FRAMES=0 acts as 1, REPEATS=1
        bus_wr(2'd2, 32'h80000100);
        pulse_hit();
        check("pf0_on", {8'h0, accent_out}, 32'hFF0000);
        ftick();
        check("pf0_off", {8'h0, accent_out}, 32'h102030);
        check("pf0_off_busy", {31'h0, busy}, 32'h1);
        ftick();
        check("pf0_done_busy", {31'h0, busy}, 32'h0);

        // REPEATS=0 ignores hit
        bus_wr(2'd2, 32'h80000003);
        pulse_hit();
        check("rep0_busy", {31'h0, busy}, 32'h0);
        check("rep0_col", {8'h0, accent_out}, 32'h102030);

        // hit and frame_tick together at frm_cnt=2
        bus_wr(2'd2, 32'h80000205);
        pulse_hit();
        ftick();
        ftick();
        bus_rd(2'd3, rd); check("pre_coll_status", rd, 32'h80000202);
        hit        = 1'b1;
        frame_tick = 1'b1;
        step();
        hit        = 1'b0;
        frame_tick = 1'b0;
        bus_rd(2'd3, rd); check("coll_status", rd, 32'h80000200);

        // STATUS write aborts, and beats a coinciding hit
        bus_wr(2'd3, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_col", {8'h0, accent_out}, 32'h102030);
        hit = 1'b1;
        bus_wr(2'd3, 32'h0);
        hit = 1'b0;
        check("abort_hit_busy", {31'h0, busy}, 32'h0);
        bus_rd(2'd3, rd); check("abort_hit_status", rd, 32'h0);

        // EN=0 mid-OFF, plus BASE write while OFF
        bus_wr(2'd2, 32'h80000203);
        pulse_hit();
        for (int i = 0; i < 3; i++) ftick();
        check("off_col", {8'h0, accent_out}, 32'h102030);
        bus_wr(2'd0, 32'h0000AA55);
        check("off_base_wr", {8'h0, accent_out}, 32'h00AA55);
        check("off_busy", {31'h0, busy}, 32'h1);
        bus_wr(2'd2, 32'h00000203);
        check("en0_busy", {31'h0, busy}, 32'h0);
        check("en0_col", {8'h0, accent_out}, 32'h00AA55);

        // FLASH write while ON, then reset mid-ON
        bus_wr(2'd2, 32'h80000203);
        pulse_hit();
        check("on2_col", {8'h0, accent_out}, 32'hFF0000);
        bus_wr(2'd1, 32'h000000FF);
        check("on_flash_wr", {8'h0, accent_out}, 32'h0000FF);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_col", {8'h0, accent_out}, 32'h0);
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        bus_rd(2'd1, rd); check("mid_rst_flash", rd, 32'h00FFFFFF);
        bus_rd(2'd2, rd); check("mid_rst_ctrl", rd, 32'h0);
        bus_rd(2'd3, rd); check("mid_rst_status", rd, 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/accent_flash_ctrl.md
Name: accent_flash_ctrl

Overview:
- Memory-mapped controller that drives one player's 24-bit accent colour into the sprite/HUD renderer.
- Holds a base colour and a flash colour. On a damage pulse from game logic, it sequences a blink pattern (flash/base alternation), timed in video frames via a frame tick.
- Sits on the NIOS Avalon-MM bus as a 4-word slave, one instance per player, replacing raw colour PIO writes during hit effects.

Parameters:
- COLOR_W, 24, accent colour width (8:8:8 RGB)
- FRAME_W, 8, width of per-phase frame counter
- REPEAT_W, 4, width of blink repeat counter

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- address  in  2  Avalon word address
- chipselect  in  1  Avalon chip select
- write_n  in  1  Avalon write strobe, active low
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data, zero wait states, combinational from address
- frame_tick  in  1  one-cycle pulse per frame (vsync edge)
- hit  in  1  one-cycle damage pulse
- accent_out  out  COLOR_W  colour to renderer, registered
- busy  out  1  high while blink sequence active

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high on `reset`.
- Register map (write when chipselect && !write_n):
  - 0 BASE[23:0]
  - 1 FLASH[23:0]
  - 2 CTRL: [7:0] PHASE_FRAMES, [11:8] REPEATS, [31] EN
  - 3 STATUS: read {busy at bit 31, remaining repeats [11:8], phase frame count [7:0]}. Any write to 3 forces abort to IDLE.
  - Unused bits read 0.
- Reset values:
  - BASE=0, FLASH=0xFFFFFF, CTRL=0 (EN=0).
  - State IDLE, counters 0, accent_out=0, busy=0.
- FSM states: IDLE, ON, OFF.
  - IDLE: accent_out=BASE. On hit && EN && REPEATS!=0, go to ON; load rep_cnt=REPEATS and frm_cnt=0.
  - ON: accent_out=FLASH. On each frame_tick, frm_cnt++. When frm_cnt+1 == max(PHASE_FRAMES,1) on a tick, go to OFF and clear frm_cnt.
  - OFF: accent_out=BASE. Same frame counting. At phase end, rep_cnt--. If the result is 0, go to IDLE; else go to ON.
- PHASE_FRAMES=0 is treated as 1. REPEATS=0 means hits are ignored.
- Latency:
  - hit high in cycle k gives accent_out=FLASH in cycle k+1.
  - A frame_tick ending a phase changes accent_out in the next cycle.
  - A BASE/FLASH write changes accent_out the next cycle when in the matching state.
- busy = (state != IDLE), registered alongside state.
- Simultaneous events:
  - hit while ON/OFF restarts the sequence: ON, rep_cnt reload, frm_cnt=0. hit has priority over a coinciding frame_tick.
  - Abort (STATUS write, or an EN=0 write) beats hit in the same cycle.
  - CTRL writes mid-sequence: new PHASE_FRAMES applies at the next compare. REPEATS takes effect only on the next (re)start.
  - Writing EN=0 mid-sequence goes to IDLE the next cycle.
- Reset mid-sequence: IDLE, accent_out=0, all registers return to reset values.
- Counters never wrap. frm_cnt is cleared at every phase boundary.

Decomposition:
- Package accent_pkg holds:
  - state enum {IDLE, ON, OFF}
  - register address constants ADDR_BASE=0, ADDR_FLASH=1, ADDR_CTRL=2, ADDR_STATUS=3
  - CTRL field bit positions
- One natural sub-module, accent_regs: the Avalon register file and read mux, producing abort/cfg strobes.
- The FSM and counters stay in the top module.

Test Plan:
- Reset, then read all 4 addresses: 0x0, 0xFFFFFF, 0x0, 0x0; accent_out=0, busy=0.
- BASE=0x102030, FLASH=0xFF0000, CTRL=EN|REPEATS=2|PHASE_FRAMES=3, hit, then 12 frame_ticks:
  - accent_out sequence FF0000 for 3 ticks, 102030 for 3, FF0000 for 3, 102030 for 3, then IDLE.
  - busy falls on the cycle after the 12th tick.
- Second hit after 4 ticks of the sequence above: restarts at ON with rep_cnt=2; STATUS reads busy=1, reps=2, frm=0; the full 12 ticks follow.
- PHASE_FRAMES=0, REPEATS=1, hit then 2 ticks: FLASH for 1 tick, BASE for 1 tick, IDLE. With REPEATS=0, hit leaves busy=0.
- hit and frame_tick in the same cycle while ON at frm_cnt=2: restart wins, frm_cnt=0.
- Abort paths:
  - STATUS write coinciding with hit: state stays IDLE.
  - EN=0 written mid-OFF: IDLE next cycle, accent_out=BASE.
  - reset asserted mid-ON: accent_out=0 next cycle.
